// File: rtl/affine_pkg.sv
// Shared types and constants for the affine core and its program loader.
// No logic; no latency.
// No flow control.
package affine;

  localparam int W_INST = 28;
  localparam int LD_BPI = 4;
  localparam int LD_PAD = 8*LD_BPI - W_INST;

  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CHK, DONE, ERR} tLdState;

endpackage

// File: rtl/affine_byte_assembler.sv
// Packs big-endian bytes into one instruction word and flags nonzero pad bits in the first byte.
// Latency: word and word_rdy are valid in the same cycle as the 4th byte.
// Backpressure: none; the loader gates shift with the accepted transfer.
module affine_byte_assembler #(
  parameter int W_INST = affine::W_INST
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              clr,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  output logic              word_rdy,
  output logic              pad_err,
  output logic [W_INST-1:0] word
);
  import affine::*;

  localparam int PAD = 8*LD_BPI - W_INST;
  localparam logic [7:0] PAD_MASK = ~(8'hFF >> PAD);

  logic [31:0] sr;
  logic [31:0] nxt;
  logic [1:0]  cnt;
  logic        unused_hi;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= nxt;
      cnt <= cnt + 2'd1;
    end
  end

  // The incoming byte completes the word combinationally so the loader can register it directly.
  assign nxt      = {sr[23:0], byte_in};
  assign word     = nxt[W_INST-1:0];
  assign word_rdy = shift && (cnt == 2'd3);
  assign pad_err  = shift && (cnt == 2'd0) && |(byte_in & PAD_MASK);

  assign unused_hi = ^{sr[31:24], nxt};

endmodule

// File: rtl/affine_prog_loader.sv
// Loads the affine core's program memory from a framed byte stream, holding the core while loading.
// Latency: pm_we one cycle after the 4th byte of each word; at most 4 bytes per 5 cycles.
// Backpressure: byte_ready low in IDLE, WRITE, DONE and ERR; unaccepted bytes stay with the source.
module affine_prog_loader #(
  parameter int P_A    = 4,
  parameter int W_INST = affine::W_INST
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              pm_we,
  output logic [P_A-1:0]    pm_addr,
  output logic [W_INST-1:0] pm_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);
  import affine::*;

  localparam logic [8:0] N_MAX = 9'(1 << P_A);

  tLdState           state;
  logic [P_A-1:0]    widx;
  logic [P_A-1:0]    last;
  logic [7:0]        chksum;
  logic [7:0]        n_m1;
  logic              xfer;
  logic              launch;
  logic              hdr_ok;
  logic              word_rdy;
  logic              pad_err;
  logic [W_INST-1:0] word;

  assign xfer   = byte_valid && byte_ready;
  assign launch = start && (state inside {IDLE, DONE, ERR});
  assign hdr_ok = (byte_in != 8'd0) && ({1'b0, byte_in} <= N_MAX);
  assign n_m1   = byte_in - 8'd1;

  affine_byte_assembler #(.W_INST(W_INST)) u_asm (
    .clk      (clk),
    .nReset   (nReset),
    .clr      (launch),
    .shift    (xfer && (state == DATA)),
    .byte_in  (byte_in),
    .word_rdy (word_rdy),
    .pad_err  (pad_err),
    .word     (word)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      widx     <= '0;
      last     <= '0;
      chksum   <= '0;
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
    end else begin
      pm_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (launch) begin
            state  <= HDR;
            widx   <= '0;
            chksum <= '0;
          end
        end
        HDR: begin
          if (xfer) begin
            chksum <= chksum ^ byte_in;
            if (hdr_ok) begin
              last  <= n_m1[P_A-1:0];
              state <= DATA;
            end else begin
              state <= ERR;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            chksum <= chksum ^ byte_in;
            if (pad_err) begin
              state <= ERR;
            end else if (word_rdy) begin
              state    <= WRITE;
              pm_we    <= 1'b1;
              pm_addr  <= widx;
              pm_wdata <= word;
            end
          end
        end
        WRITE: begin
          // Stop on the last index instead of incrementing, so a full 2^P_A load never wraps.
          if (widx == last) begin
            state <= CHK;
          end else begin
            widx  <= widx + 1'b1;
            state <= DATA;
          end
        end
        CHK: begin
          if (xfer) state <= (byte_in == chksum) ? DONE : ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign byte_ready = state inside {HDR, DATA, CHK};
  assign core_hold  = state inside {HDR, DATA, WRITE, CHK, ERR};
  assign done       = (state == DONE);
  assign err        = (state == ERR);

endmodule
